// File: rtl/sts_control_pkg.sv
// ---------------------------------------------------------------------------
// sts_control_pkg
// Purpose : shared definitions for the status/completion controller.
//           Holds the FSM state encoding, the default status tag, a clog2
//           helper for counter sizing and the status word field layout
//           (the same layout the host driver header decodes).
// Ports   : none (package)
// ---------------------------------------------------------------------------
package sts_control_pkg;

   // Two-bit encoding leaves spare codes; any of them recovers to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_FIN = 2'd1
   } state_t;

   localparam logic [7:0] DEFAULT_STATUS_TAG = 8'hD0;

   // Status word layout: {tag, reserved, seq}
   localparam int STS_TAG_MSB  = 31;
   localparam int STS_TAG_LSB  = 24;
   localparam int STS_RSVD_MSB = 23;
   localparam int STS_RSVD_LSB = 16;
   localparam int STS_SEQ_MSB  = 15;
   localparam int STS_SEQ_LSB  = 0;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic logic [31:0] status_word(input logic [7:0] tag, input logic [15:0] seq);
      logic [31:0] w;
      w = '0;
      w[STS_TAG_MSB:STS_TAG_LSB]   = tag;
      w[STS_RSVD_MSB:STS_RSVD_LSB] = 8'h00;
      w[STS_SEQ_MSB:STS_SEQ_LSB]   = seq;
      return w;
   endfunction

endpackage

// File: rtl/sts_control_bram_finish_tracker.sv
// ---------------------------------------------------------------------------
// sts_control_bram_finish_tracker
// Purpose : one sticky "finished" flag per output BRAM controller, plus the
//           all-finished reduction the completion FSM waits on.
// Ports   : clk, rstn        clock, async active-low reset
//           i_finished       per-BRAM one-cycle finished pulses
//           i_clear          clears all flags (status write issue cycle)
//           o_all_finished   every flag set (constant 1 with no BRAMs)
// ---------------------------------------------------------------------------
module sts_control_bram_finish_tracker #(
   parameter int NUM_BRAMS = 0
) (
   input  logic                                      clk,
   input  logic                                      rstn,
   input  logic [(NUM_BRAMS > 0 ? NUM_BRAMS : 1)-1:0] i_finished,
   input  logic                                      i_clear,
   output logic                                      o_all_finished
);

   generate
      if (NUM_BRAMS == 0) begin : g_no_brams
         // No BRAM dependency: the tracker is transparent.
         logic w_unused;
         assign w_unused       = ^{clk, rstn, i_finished, i_clear};
         assign o_all_finished = 1'b1;
      end else begin : g_brams
         logic [NUM_BRAMS-1:0] r_flags;

         // A pulse arriving on the clear cycle belongs to the next call,
         // so set wins over clear.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_flags <= '0;
            end else begin
               r_flags <= (r_flags & ~{NUM_BRAMS{i_clear}}) | i_finished;
            end
         end

         assign o_all_finished = &r_flags;
      end
   endgenerate

endmodule

// File: rtl/sts_control.sv
// ---------------------------------------------------------------------------
// sts_control
// Purpose : completion side of the accelerator command path. Tracks launched
//           and completed calls, waits for all output BRAM controllers to
//           drain each completed call, then pushes one status word per call
//           into the status queue.
// Ports   : clk, rstn              clock, async active-low reset
//           ap_start_single        launch pulse
//           ap_done                completion pulse
//           outbram_ctrl_finished  per-BRAM drained pulses
//           dout, write            status word and its write strobe
//           full                   status queue full (stalls the write)
//           busy                   work in flight or FSM not idle
//           err                    sticky protocol error
// ---------------------------------------------------------------------------
module sts_control
   import sts_control_pkg::*;
#(
   parameter int          NUM_OUTPUT_BRAMs = 0,
   parameter int          MAX_OUTSTANDING  = 4,
   parameter logic [7:0]  STATUS_TAG       = DEFAULT_STATUS_TAG
) (
   input  logic                                                    clk,
   input  logic                                                    rstn,
   input  logic                                                    ap_start_single,
   input  logic                                                    ap_done,
   input  logic [(NUM_OUTPUT_BRAMs > 0 ? NUM_OUTPUT_BRAMs : 1)-1:0] outbram_ctrl_finished,
   output logic [31:0]                                             dout,
   output logic                                                    write,
   input  logic                                                    full,
   output logic                                                    busy,
   output logic                                                    err
);

   localparam int            CW      = clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW:0]   MAX_SUM = (CW + 1)'(MAX_OUTSTANDING);

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_launched_cnt;
   logic [CW-1:0] r_done_cnt;
   logic [15:0]   r_seq;
   logic [31:0]   r_dout;
   logic          r_write;
   logic          r_err;

   logic [CW:0]   w_outstanding;
   logic          w_room;
   logic          w_start_ok;
   logic          w_done_ok;
   logic          w_start_err;
   logic          w_done_err;
   logic          w_issue;
   logic          w_all_finished;

   sts_control_bram_finish_tracker #(
      .NUM_BRAMS (NUM_OUTPUT_BRAMs)
   ) u_tracker (
      .clk            (clk),
      .rstn           (rstn),
      .i_finished     (outbram_ctrl_finished),
      .i_clear        (w_issue),
      .o_all_finished (w_all_finished)
   );

   // Launched and completed-but-unreported calls share one budget.
   assign w_outstanding = {1'b0, r_launched_cnt} + {1'b0, r_done_cnt};
   assign w_room        = (w_outstanding < MAX_SUM);
   assign w_start_ok    = ap_start_single & w_room;
   assign w_start_err   = ap_start_single & ~w_room;
   // A done is legal if something is in flight, or a launch lands alongside it.
   assign w_done_ok     = ap_done & ((r_launched_cnt != '0) | w_start_ok);
   assign w_done_err    = ap_done & (r_launched_cnt == '0) & ~ap_start_single;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_done_cnt != '0) begin
               w_state_next = ST_WAIT_FIN;
            end
         end
         ST_WAIT_FIN: begin
            // full only stalls; the word is issued once space appears.
            if (w_all_finished && !full) begin
               w_issue      = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_write        <= 1'b0;
         r_dout         <= '0;
         r_seq          <= '0;
         r_launched_cnt <= '0;
         r_done_cnt     <= '0;
         r_err          <= 1'b0;
      end else begin
         r_write <= w_issue;
         if (w_issue) begin
            r_dout <= status_word(STATUS_TAG, r_seq);
            r_seq  <= r_seq + 16'd1;
         end

         case ({w_start_ok, w_done_ok})
            2'b10:   r_launched_cnt <= r_launched_cnt + CW'(1);
            2'b01:   r_launched_cnt <= r_launched_cnt - CW'(1);
            default: r_launched_cnt <= r_launched_cnt;
         endcase

         case ({w_done_ok, w_issue})
            2'b10:   r_done_cnt <= r_done_cnt + CW'(1);
            2'b01:   r_done_cnt <= r_done_cnt - CW'(1);
            default: r_done_cnt <= r_done_cnt;
         endcase

         if (w_start_err || w_done_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign dout  = r_dout;
   assign write = r_write;
   assign err   = r_err;
   assign busy  = (r_state != ST_IDLE) | (r_launched_cnt != '0) | (r_done_cnt != '0);

endmodule

// File: tb/tb_sts_control.sv
// ---------------------------------------------------------------------------
// tb_sts_control
// Two instances share start/done/full: dut_a waits on two output BRAMs,
// dut_b has no BRAM dependency. A call-level model predicts both every cycle;
// directed checks pin the absolute values of key scenarios.
// ---------------------------------------------------------------------------
module tb_sts_control;

   localparam int MAXO = 4;

   typedef struct {
      int          launched;
      int          pending;
      logic [1:0]  flags;
      bit          armed;
      int          issued;
      bit          err;
      bit          write;
      logic [31:0] dout;
   } mstate_t;

   logic        clk   = 1'b0;
   logic        rstn  = 1'b0;
   logic        start = 1'b0;
   logic        done  = 1'b0;
   logic        full  = 1'b0;
   logic [1:0]  fin_a = 2'b00;
   logic [0:0]  fin_b = 1'b0;

   logic [31:0] dout_a, dout_b;
   logic        write_a, write_b, busy_a, busy_b, err_a, err_b;

   int          checks = 0;
   int          errors = 0;
   bit          cmp_en = 1'b0;
   logic [15:0] seq_base_b = 16'h0000;
   mstate_t     m [2];

   int          cycle = 0;
   logic [31:0] dq_a[$];
   logic [31:0] dq_b[$];
   int          wc_a[$];
   int          wc_b[$];
   int          na, nb;

   always #5 clk = ~clk;

   sts_control #(.NUM_OUTPUT_BRAMs(2), .MAX_OUTSTANDING(MAXO), .STATUS_TAG(8'hD0)) dut_a (
      .clk(clk), .rstn(rstn), .ap_start_single(start), .ap_done(done),
      .outbram_ctrl_finished(fin_a), .dout(dout_a), .write(write_a),
      .full(full), .busy(busy_a), .err(err_a));

   sts_control #(.NUM_OUTPUT_BRAMs(0), .MAX_OUTSTANDING(MAXO), .STATUS_TAG(8'hD0)) dut_b (
      .clk(clk), .rstn(rstn), .ap_start_single(start), .ap_done(done),
      .outbram_ctrl_finished(fin_b), .dout(dout_b), .write(write_b),
      .full(full), .busy(busy_b), .err(err_b));

   // ---------------- call-level model ----------------
   function automatic mstate_t model_reset();
      mstate_t r;
      r.launched = 0; r.pending = 0; r.flags = 2'b00; r.armed = 1'b0;
      r.issued = 0; r.err = 1'b0; r.write = 1'b0; r.dout = 32'h0;
      return r;
   endfunction

   // One clock of the completion rules: a completed call is reported one
   // cycle after the controller notices it, once every BRAM has drained it
   // and the queue has space.
   function automatic mstate_t step(mstate_t c, bit has_brams, bit st, bit dn, bit fl,
                                    logic [1:0] fin, logic [15:0] base);
      mstate_t n;
      bit all_fin, issue, start_ok, done_ok;
      logic [15:0] s;
      n        = c;
      all_fin  = has_brams ? (c.flags == 2'b11) : 1'b1;
      issue    = c.armed && all_fin && !fl;
      start_ok = st && ((c.launched + c.pending) < MAXO);
      done_ok  = dn && ((c.launched > 0) || start_ok);
      n.write  = issue;
      if (issue) begin
         s        = 16'(int'(base) + c.issued);
         n.dout   = {8'hD0, 8'h00, s};
         n.issued = c.issued + 1;
      end
      n.launched = c.launched + int'(start_ok) - int'(done_ok);
      n.pending  = c.pending + int'(done_ok) - int'(issue);
      n.flags    = (issue ? 2'b00 : c.flags) | (has_brams ? fin : 2'b00);
      n.armed    = issue ? 1'b0 : (c.armed || (c.pending > 0));
      n.err      = c.err || (st && !start_ok) || (dn && (c.launched == 0) && !st);
      return n;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m[0] <= model_reset();
         m[1] <= model_reset();
      end else begin
         m[0] <= step(m[0], 1'b1, start, done, full, fin_a, 16'h0000);
         m[1] <= step(m[1], 1'b0, start, done, full, 2'b00, seq_base_b);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_inst(input string tag, input mstate_t e, input logic w,
                               input logic [31:0] d, input logic b, input logic er);
      bit eb;
      eb = e.armed || (e.launched != 0) || (e.pending != 0);
      check({tag, "_write"}, {31'b0, w}, {31'b0, e.write});
      check({tag, "_dout"}, d, e.dout);
      check({tag, "_busy"}, {31'b0, b}, {31'b0, eb});
      check({tag, "_err"}, {31'b0, er}, {31'b0, e.err});
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         compare_inst("a", m[0], write_a, dout_a, busy_a, err_a);
         compare_inst("b", m[1], write_b, dout_b, busy_b, err_b);
      end
   end

   // write log for directed checks
   always @(negedge clk) begin
      cycle <= cycle + 1;
      if (write_a === 1'b1) begin
         dq_a.push_back(dout_a);
         wc_a.push_back(cycle);
         $display("[%0d] a write %h", cycle, dout_a);
      end
      if (write_b === 1'b1) begin
         dq_b.push_back(dout_b);
         wc_b.push_back(cycle);
         $display("[%0d] b write %h", cycle, dout_b);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rstn       = 1'b0;
      seq_base_b = 16'h0000;
      cyc(2);
      rstn = 1'b1;
      cyc(1);
   endtask

   task automatic mark();
      na = dq_a.size();
      nb = dq_b.size();
   endtask

   initial begin
      do_reset();
      cmp_en = 1'b1;

      // reset state
      check("rst_write_a", {31'b0, write_a}, 32'd0);
      check("rst_dout_b", dout_b, 32'h0);
      check("rst_busy_a", {31'b0, busy_a}, 32'd0);
      check("rst_err_b", {31'b0, err_b}, 32'd0);

      // 1: single call, done 5 cycles after start
      mark();
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(4);
      done = 1'b1; fin_a = 2'b11; cyc(1); done = 1'b0; fin_a = 2'b00;
      cyc(8);
      check("t1_cnt_b", dq_b.size() - nb, 1);
      check("t1_dout_b", dq_b[dq_b.size()-1], 32'hD000_0000);
      check("t1_cnt_a", dq_a.size() - na, 1);
      check("t1_busy_b", {31'b0, busy_b}, 32'd0);

      // 2: BRAM finishes at +3 and +10 after done
      do_reset();
      mark();
      start = 1'b1; cyc(1); start = 1'b0;
      done = 1'b1; cyc(1); done = 1'b0;
      cyc(2);
      fin_a = 2'b01; cyc(1); fin_a = 2'b00;
      cyc(6);
      check("t2_wait_a", dq_a.size() - na, 0);
      fin_a = 2'b10; cyc(1); fin_a = 2'b00;
      cyc(4);
      check("t2_cnt_a", dq_a.size() - na, 1);
      check("t2_dout_a", dq_a[dq_a.size()-1], 32'hD000_0000);
      // flags must have been cleared: next call waits for fresh pulses
      start = 1'b1; cyc(1); start = 1'b0;
      done = 1'b1; cyc(1); done = 1'b0;
      cyc(8);
      check("t2_clr_a", dq_a.size() - na, 1);
      fin_a = 2'b11; cyc(1); fin_a = 2'b00;
      cyc(4);
      check("t2_cnt2_a", dq_a.size() - na, 2);
      check("t2_dout2_a", dq_a[dq_a.size()-1], 32'hD000_0001);

      // 3: queue full stalls the report
      do_reset();
      mark();
      full = 1'b1;
      start = 1'b1; cyc(1); start = 1'b0;
      done = 1'b1; fin_a = 2'b11; cyc(1); done = 1'b0; fin_a = 2'b00;
      cyc(20);
      check("t3_stall_a", dq_a.size() - na, 0);
      check("t3_stall_b", dq_b.size() - nb, 0);
      check("t3_busy_b", {31'b0, busy_b}, 32'd1);
      full = 1'b0;
      cyc(4);
      check("t3_cnt_a", dq_a.size() - na, 1);
      check("t3_cnt_b", dq_b.size() - nb, 1);
      check("t3_dout_b", dq_b[dq_b.size()-1], 32'hD000_0000);

      // 4: three back-to-back calls
      do_reset();
      mark();
      start = 1'b1; cyc(3); start = 1'b0;
      done = 1'b1; fin_a = 2'b11; cyc(3); done = 1'b0;
      cyc(8);
      fin_a = 2'b00;
      cyc(4);
      check("t4_cnt_b", dq_b.size() - nb, 3);
      check("t4_cnt_a", dq_a.size() - na, 3);
      check("t4_seq0_b", dq_b[nb], 32'hD000_0000);
      check("t4_seq1_b", dq_b[nb+1], 32'hD000_0001);
      check("t4_seq2_b", dq_b[nb+2], 32'hD000_0002);
      check("t4_seq2_a", dq_a[na+2], 32'hD000_0002);
      check("t4_gap_b", wc_b[nb+1] - wc_b[nb], 2);
      check("t4_gap_a", wc_a[na+2] - wc_a[na+1], 2);

      // 5: outstanding limit
      do_reset();
      mark();
      start = 1'b1; cyc(4);
      check("t5_err4_b", {31'b0, err_b}, 32'd0);
      cyc(1); start = 1'b0;
      check("t5_err5_a", {31'b0, err_a}, 32'd1);
      check("t5_err5_b", {31'b0, err_b}, 32'd1);
      done = 1'b1; fin_a = 2'b11; cyc(4); done = 1'b0;
      cyc(10);
      fin_a = 2'b00;
      check("t5_cnt_b", dq_b.size() - nb, 4);
      check("t5_cnt_a", dq_a.size() - na, 4);
      done = 1'b1; cyc(1); done = 1'b0;
      cyc(4);
      check("t5_extra_b", dq_b.size() - nb, 4);
      check("t5_sticky_b", {31'b0, err_b}, 32'd1);
      check("t5_idle_b", {31'b0, busy_b}, 32'd0);

      // 5b: done with nothing launched
      do_reset();
      mark();
      check("t5b_err0_b", {31'b0, err_b}, 32'd0);
      done = 1'b1; cyc(1); done = 1'b0;
      cyc(1);
      check("t5b_err_b", {31'b0, err_b}, 32'd1);
      check("t5b_err_a", {31'b0, err_a}, 32'd1);
      cyc(4);
      check("t5b_cnt_b", dq_b.size() - nb, 0);

      // 6: seq wrap, then reset during a write cycle
      do_reset();
      mark();
      force dut_b.r_seq = 16'hFFFF;
      seq_base_b = 16'hFFFF;
      cyc(1);
      release dut_b.r_seq;
      repeat (2) begin
         start = 1'b1; cyc(1); start = 1'b0;
         done = 1'b1; cyc(1); done = 1'b0;
         cyc(5);
      end
      check("t6_ffff_b", dq_b[nb], 32'hD000_FFFF);
      check("t6_wrap_b", dq_b[nb+1], 32'hD000_0000);
      start = 1'b1; cyc(1); start = 1'b0;
      done = 1'b1; cyc(1); done = 1'b0;
      cyc(1);
      @(posedge clk);
      #1;
      check("t6_wr_hi_b", {31'b0, write_b}, 32'd1);
      #1;
      rstn       = 1'b0;
      seq_base_b = 16'h0000;
      #1;
      check("t6_wr_rst_b", {31'b0, write_b}, 32'd0);
      check("t6_dout_rst_b", dout_b, 32'h0);
      check("t6_busy_rst_b", {31'b0, busy_b}, 32'd0);
      check("t6_busy_rst_a", {31'b0, busy_a}, 32'd0);
      cyc(2);
      rstn = 1'b1;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sts_control.md
Name: sts_control

Overview:
- Completion side of the accelerator command path; the counterpart to the command-dequeue/start controller.
- Counts launched calls (ap_start_single) and completed calls (ap_done).
- Waits until every output BRAM controller reports finished for the completed call, then pushes one 32-bit status word per call into the status (response) queue.
- Host software pops one status word per issued command.

Parameters:
- NUM_OUTPUT_BRAMs, 0, number of output BRAM controllers to wait on; 0 = no BRAM dependency.
- MAX_OUTSTANDING, 4, maximum launched-but-not-reported calls; counter width CW = clog2(MAX_OUTSTANDING+1).
- STATUS_TAG, 8'hD0, constant placed in dout[31:24].

Ports:
- clk  in  1  single clock.
- rstn  in  1  reset; asynchronous, active-low.
- ap_start_single  in  1  one-cycle pulse per accelerator launch.
- ap_done  in  1  one-cycle pulse per accelerator completion.
- outbram_ctrl_finished  in  max(NUM_OUTPUT_BRAMs,1)  per-BRAM one-cycle pulse: output data drained for one call.
- dout  out  32  status word {STATUS_TAG, 8'h00, seq[15:0]}.
- write  out  1  status queue write strobe, one cycle per word.
- full  in  1  status queue full.
- busy  out  1  high while any call is launched, completed-unreported, or the FSM is not idle.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, rstn=0): state=IDLE, write=0, dout=0, err=0, seq=0, all counters 0, sticky flags 0. Applies immediately mid-operation, including during a write cycle; a pending status is lost.
- launched_cnt (CW bits):
  - +1 on ap_start_single, -1 on ap_done.
  - Both in the same cycle: unchanged.
- done_cnt (CW bits):
  - +1 on ap_done, -1 on the status write issue cycle.
  - Both in the same cycle: unchanged.
- err set (sticky until reset) when any of these occur:
  - ap_start_single while launched_cnt+done_cnt == MAX_OUTSTANDING; counter does not increment.
  - ap_done while launched_cnt == 0 and no simultaneous ap_start_single; counters unchanged.
- Finish flags, one sticky bit per BRAM:
  - Set on an outbram_ctrl_finished pulse; cleared on the write issue cycle.
  - A pulse coincident with the clear leaves the bit set; it belongs to the next call.
  - all_finished = &flags, or 1 when NUM_OUTPUT_BRAMs == 0.
- FSM:
  - IDLE: done_cnt != 0 -> WAIT_FIN.
  - WAIT_FIN: all_finished & ~full -> issue: write<=1, dout<=word(seq), seq<=seq+1, done_cnt-1, clear flags, state<=IDLE.
  - WAIT_FIN otherwise: hold with write=0. full only stalls; no word is dropped.
  - Unreachable state encodings -> IDLE.
- write is registered, high exactly one cycle per status word, never while full was sampled high on the issue edge.
- Latency (no stall, flags already set): ap_done sampled at edge N -> write high between edges N+2 and N+3.
- Throughput: one status word per 2 cycles maximum.
- seq is 16 bits and wraps 0xFFFF -> 0x0000.
- busy = (state != IDLE) | (launched_cnt != 0) | (done_cnt != 0), combinational.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, WAIT_FIN=1);
  - STATUS_TAG default;
  - clog2 function for CW;
  - status word field offsets (tag 31:24, rsvd 23:16, seq 15:0), shared with the host driver header.
- One natural sub-module: bram_finish_tracker.
  - Contains the sticky flag bank plus all_finished reduction.
  - Inputs: finished pulses, clear.
  - Output: all_finished.

Test Plan:
- NUM_OUTPUT_BRAMs=0; ap_start_single, then ap_done 5 cycles later -> one write, dout=32'hD0000000; busy low 1 cycle after write.
- NUM_OUTPUT_BRAMs=2; ap_done, finished[0] at +3, finished[1] at +10 -> write only after finished[1]; dout seq=0; flags cleared.
- full held high 20 cycles after ap_done -> write stays 0; full drops -> exactly one write with seq intact.
- 3 back-to-back calls with ap_done pulses 1 cycle apart -> 3 writes, seq 0,1,2, writes spaced ≥2 cycles.
- MAX_OUTSTANDING=4: 5 ap_start_single, no done -> err=1 after 5th, launched_cnt=4; ap_done with launched_cnt=0 -> err stays set.
- seq preloaded to 0xFFFF by 65535 calls (or force) -> next dout[15:0]=0xFFFF, following 0x0000; assert rstn low during write cycle -> write drops to 0 immediately, busy=0.
